adc_serial_emu_gen: RTL and testbench

//  Parametrised synthesizable emulator of an N-channel serial-LVDS ADC (LTC2174 style) for sim and loopback.

---
 rtl/adc_serial_emu_pkg.sv | 35 +++
 rtl/adc_serial_emu_gen_chan.sv | 102 ++++++++++
 rtl/adc_serial_emu_gen.sv | 101 ++++++++++
 tb/tb_adc_serial_emu_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_emu_pkg.sv
// Shared types and constants for the serial-LVDS ADC emulator.
//   t_emu_mode    : per-channel waveform selector
//   t_emu_state   : frame sequencer state
//   LfsrPoly/Seed : Galois PRBS polynomial (x^16+x^14+x^13+x^11+1) and base seed
//   f_padded_word : left-aligns a sample inside the 2*frame_len bit serial word
package adc_serial_emu_pkg;

  typedef enum logic [1:0] {
    ModeConst    = 2'd0,
    ModeTriangle = 2'd1,
    ModeSawtooth = 2'd2,
    ModePrbs     = 2'd3
  } t_emu_mode;

  typedef enum logic {
    StIdle,
    StRun
  } t_emu_state;

  localparam logic [15:0] LfsrPoly = 16'hB400;
  localparam logic [15:0] LfsrSeed = 16'hACE1;

  localparam int unsigned MaxWordW = 64;

  // Sample (zero-extended to 32 bits) shifted so its MSB lands on bit 2*frame_len-1;
  // the bit-times past the sample carry zeros.
  function automatic logic [MaxWordW-1:0] f_padded_word(input logic [31:0] sample,
                                                        input int unsigned res,
                                                        input int unsigned frame_len);
    logic [MaxWordW-1:0] word;
    word = {32'b0, sample} << (2 * frame_len - res);
    return word;
  endfunction

endpackage

// File: rtl/adc_serial_emu_gen_chan.sv
// One emulated ADC channel: sample register, triangle direction, PRBS LFSR, mode mux and
// two-lane MSB-first shift-out.
//   clk_i, rst_i   : bit clock, async active-high reset
//   update_i       : compute next sample (asserted on the cycle before a frame's count 0)
//   run_i, cnt_i   : sequencer state and bit counter from the top
//   mode_i, step_i, limit_i, const_i : waveform configuration
//   lane_odd_o/lane_even_o : serial lanes (0 when not running)
//   sample_o       : sample currently being serialised
module adc_serial_emu_gen_chan
  import adc_serial_emu_pkg::*;
#(
  parameter int unsigned g_RES       = 14,
  parameter int unsigned g_FRAME_LEN = 8,
  parameter int unsigned g_CHAN_IDX  = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           update_i,
  input  logic                           run_i,
  input  logic [$clog2(g_FRAME_LEN)-1:0] cnt_i,
  input  logic [1:0]                     mode_i,
  input  logic [g_RES-1:0]               step_i,
  input  logic [g_RES-1:0]               limit_i,
  input  logic [g_RES-1:0]               const_i,
  output logic                           lane_odd_o,
  output logic                           lane_even_o,
  output logic [g_RES-1:0]               sample_o
);

  localparam int unsigned W     = g_RES + 2;
  localparam int unsigned WordW = 2 * g_FRAME_LEN;
  localparam int unsigned SelW  = $clog2(WordW);
  localparam logic signed [W-1:0] SMax = signed'({3'b000, {(g_RES-1){1'b1}}});
  localparam logic signed [W-1:0] SMin = signed'({3'b111, {(g_RES-1){1'b0}}});

  logic [g_RES-1:0]    sample_q, sample_d;
  logic                dir_up_q, dir_up_d;
  logic [15:0]         lfsr_q, lfsr_d;
  t_emu_mode           mode;
  logic signed [W-1:0] s_ext, lim_ext, step_ext, tri_sum;
  logic                tri_dir;
  logic [WordW-1:0]    padded;
  logic [SelW-1:0]     bit_sel;

  always_comb begin
    mode     = t_emu_mode'(mode_i);
    s_ext    = signed'({{2{sample_q[g_RES-1]}}, sample_q});
    lim_ext  = signed'({2'b00, limit_i});
    step_ext = signed'({2'b00, step_i});

    // Turn around once past +/-limit, then step; clipping at full scale also turns around.
    tri_dir = dir_up_q;
    if (s_ext > lim_ext || s_ext < -lim_ext) tri_dir = ~tri_dir;
    tri_sum = tri_dir ? s_ext + step_ext : s_ext - step_ext;
    if (tri_sum > SMax) begin
      tri_sum = SMax;
      tri_dir = ~tri_dir;
    end else if (tri_sum < SMin) begin
      tri_sum = SMin;
      tri_dir = ~tri_dir;
    end

    sample_d = sample_q;
    dir_up_d = dir_up_q;
    lfsr_d   = lfsr_q;
    if (update_i) begin
      unique case (mode)
        ModeConst:    sample_d = const_i;
        ModeTriangle: begin
          sample_d = tri_sum[g_RES-1:0];
          dir_up_d = tri_dir;
        end
        ModeSawtooth: sample_d = sample_q + step_i;
        ModePrbs:     begin
          lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrPoly : 16'h0);
          sample_d = lfsr_d[15 -: g_RES];
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q <= '0;
      dir_up_q <= 1'b1;
      lfsr_q   <= LfsrSeed + 16'(g_CHAN_IDX);
    end else begin
      sample_q <= sample_d;
      dir_up_q <= dir_up_d;
      lfsr_q   <= lfsr_d;
    end
  end

  always_comb begin
    padded      = WordW'(f_padded_word(32'(sample_q), g_RES, g_FRAME_LEN));
    bit_sel     = SelW'(WordW - 2 - 2 * int'(cnt_i));
    lane_odd_o  = run_i & padded[bit_sel + SelW'(1)];
    lane_even_o = run_i & padded[bit_sel];
    sample_o    = sample_q;
  end

endmodule

// File: rtl/adc_serial_emu_gen.sv
// N-channel serial-LVDS ADC emulator (LTC2174 style), one bit per lane per clock.
//   clk_i, rst_i        : bit clock, async active-high reset
//   en_i                : run enable, honoured only at frame boundaries
//   mode_i/step_i/limit_i/const_i : waveform configuration (per channel / shared)
//   frame_o             : 50% duty frame strobe, high for the first half of each frame
//   lane_odd_o/even_o   : per-channel serial lanes, MSB first
//   sample_o            : samples currently being serialised
//   sample_valid_o      : pulse on the first bit-time of each active frame
module adc_serial_emu_gen
  import adc_serial_emu_pkg::*;
#(
  parameter int unsigned g_NUM_CHANNELS = 4,
  parameter int unsigned g_RES          = 14,
  parameter int unsigned g_FRAME_LEN    = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              en_i,
  input  logic [2*g_NUM_CHANNELS-1:0]       mode_i,
  input  logic [g_RES-1:0]                  step_i,
  input  logic [g_RES-1:0]                  limit_i,
  input  logic [g_RES*g_NUM_CHANNELS-1:0]   const_i,
  output logic                              frame_o,
  output logic [g_NUM_CHANNELS-1:0]         lane_odd_o,
  output logic [g_NUM_CHANNELS-1:0]         lane_even_o,
  output logic [g_RES*g_NUM_CHANNELS-1:0]   sample_o,
  output logic                              sample_valid_o
);

  localparam int unsigned CntW = $clog2(g_FRAME_LEN);
  localparam logic [CntW-1:0] CntLast = CntW'(g_FRAME_LEN - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(g_FRAME_LEN / 2);

  t_emu_state      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            update;
  logic            run;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new sample is computed only when another active frame is about to start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    update  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en_i) begin
          state_d = StRun;
          update  = 1'b1;
        end
      end
      StRun: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (en_i) update = 1'b1;
          else state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    run            = (state_q == StRun);
    frame_o        = run && (cnt_q < CntHalf);
    sample_valid_o = run && (cnt_q == '0);
  end

  for (genvar k = 0; k < int'(g_NUM_CHANNELS); k++) begin : g_chan
    adc_serial_emu_gen_chan #(
      .g_RES       (g_RES),
      .g_FRAME_LEN (g_FRAME_LEN),
      .g_CHAN_IDX  (k)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .update_i    (update),
      .run_i       (run),
      .cnt_i       (cnt_q),
      .mode_i      (mode_i[2*k +: 2]),
      .step_i      (step_i),
      .limit_i     (limit_i),
      .const_i     (const_i[g_RES*k +: g_RES]),
      .lane_odd_o  (lane_odd_o[k]),
      .lane_even_o (lane_even_o[k]),
      .sample_o    (sample_o[g_RES*k +: g_RES])
    );
  end

endmodule

// File: tb/tb_adc_serial_emu_gen.sv
module tb_adc_serial_emu_gen;

  localparam int N    = 4;
  localparam int R    = 14;
  localparam int L    = 8;
  localparam int Half = 1 << (R - 1);
  localparam int Full = 1 << R;

  logic           clk_i   = 1'b0;
  logic           rst_i   = 1'b1;
  logic           en_i    = 1'b0;
  logic [2*N-1:0] mode_i  = '0;
  logic [R-1:0]   step_i  = '0;
  logic [R-1:0]   limit_i = '0;
  logic [R*N-1:0] const_i = '0;
  logic           frame_o, sample_valid_o;
  logic [N-1:0]   lane_odd_o, lane_even_o;
  logic [R*N-1:0] sample_o;

  int total = 0;
  int bad   = 0;

  adc_serial_emu_gen #(
    .g_NUM_CHANNELS (N),
    .g_RES          (R),
    .g_FRAME_LEN    (L)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .mode_i         (mode_i),
    .step_i         (step_i),
    .limit_i        (limit_i),
    .const_i        (const_i),
    .frame_o        (frame_o),
    .lane_odd_o     (lane_odd_o),
    .lane_even_o    (lane_even_o),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame level, integer arithmetic) ----------------
  int m_active = 0;
  int m_pos    = 0;
  int ms[N];
  bit mdir[N];
  int mlfsr[N];

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      ms[k]    = 0;
      mdir[k]  = 1'b1;
      mlfsr[k] = 'hACE1 + k;
    end
    m_active = 0;
    m_pos    = 0;
  endtask

  task automatic m_next_samples();
    int s;
    int lsb;
    for (int k = 0; k < N; k++) begin
      case (mode_i[2*k +: 2])
        2'd0: ms[k] = int'(const_i[R*k +: R]);
        2'd1: begin
          s = (ms[k] >= Half) ? ms[k] - Full : ms[k];
          if (s > int'(limit_i) || s < -int'(limit_i)) mdir[k] = !mdir[k];
          s = mdir[k] ? s + int'(step_i) : s - int'(step_i);
          if (s > Half - 1) begin
            s = Half - 1;
            mdir[k] = !mdir[k];
          end else if (s < -Half) begin
            s = -Half;
            mdir[k] = !mdir[k];
          end
          ms[k] = s & (Full - 1);
        end
        2'd2: ms[k] = (ms[k] + int'(step_i)) % Full;
        default: begin
          lsb = mlfsr[k] & 1;
          mlfsr[k] = mlfsr[k] >> 1;
          if (lsb != 0) mlfsr[k] = mlfsr[k] ^ 'hB400;
          ms[k] = mlfsr[k] >> (16 - R);
        end
      endcase
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) m_reset();
      else if (m_active == 0) begin
        if (en_i) begin
          m_next_samples();
          m_active = 1;
          m_pos    = 0;
        end
      end else if (m_pos == L - 1) begin
        m_pos = 0;
        if (en_i) m_next_samples();
        else m_active = 0;
      end else begin
        m_pos++;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    logic [N-1:0]   eo, ee;
    logic [R*N-1:0] es;
    int p;
    forever begin
      @(negedge clk_i);
      for (int k = 0; k < N; k++) begin
        p  = ms[k] << (2 * L - R);
        eo[k] = (m_active != 0) && (((p >> (2 * L - 1 - 2 * m_pos)) & 1) != 0);
        ee[k] = (m_active != 0) && (((p >> (2 * L - 2 - 2 * m_pos)) & 1) != 0);
        es[R*k +: R] = R'(ms[k]);
      end
      chk("model_frame", 64'(frame_o), 64'((m_active != 0) && (m_pos < L / 2)));
      chk("model_valid", 64'(sample_valid_o), 64'((m_active != 0) && (m_pos == 0)));
      chk("model_lane_odd", 64'(lane_odd_o), 64'(eo));
      chk("model_lane_even", 64'(lane_even_o), 64'(ee));
      chk("model_sample", 64'(sample_o), 64'(es));
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  logic [7:0]   odd_pat = 8'b1111_1110;
  logic [7:0]   frm_pat = 8'b1111_0000;
  logic [R-1:0] saw_exp[5];
  logic [R-1:0] tri_s[206];

  initial begin
    saw_exp[0] = 14'h1000;
    saw_exp[1] = 14'h2000;
    saw_exp[2] = 14'h3000;
    saw_exp[3] = 14'h0000;
    saw_exp[4] = 14'h1000;

    repeat (1) @(negedge clk_i);
    chk("rst_frame", 64'(frame_o), 64'd0);
    chk("rst_valid", 64'(sample_valid_o), 64'd0);
    chk("rst_lanes", 64'({lane_odd_o, lane_even_o}), 64'd0);
    chk("rst_sample", 64'(sample_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // CONST 14'h2AAA on ch0
    const_i = {14'h0001, 14'h3FFF, 14'h1555, 14'h2AAA};
    mode_i  = '0;
    en_i    = 1'b1;
    for (int i = 0; i < L; i++) begin
      @(negedge clk_i);
      chk("const_lane_odd", 64'(lane_odd_o[0]), 64'(odd_pat[7-i]));
      chk("const_lane_even", 64'(lane_even_o[0]), 64'd0);
      chk("const_frame", 64'(frame_o), 64'(frm_pat[7-i]));
      if (i == 0) begin
        chk("const_sample", 64'(sample_o[R-1:0]), 64'h2AAA);
        chk("const_valid", 64'(sample_valid_o), 64'd1);
      end
    end

    // Park ch0 at 0, then sawtooth with wrap
    const_i[R-1:0] = '0;
    @(negedge clk_i);
    repeat (L - 1) @(negedge clk_i);
    mode_i[1:0] = 2'd2;
    step_i      = 14'h1000;
    for (int f = 0; f < 5; f++) begin
      @(negedge clk_i);
      chk("saw_sample", 64'(sample_o[R-1:0]), 64'(saw_exp[f]));
      repeat (L - 1) @(negedge clk_i);
    end

    // Back to 0, then triangle step 8 limit 400
    mode_i[1:0] = 2'd0;
    @(negedge clk_i);
    repeat (L - 1) @(negedge clk_i);
    mode_i[1:0] = 2'd1;
    step_i      = 14'd8;
    limit_i     = 14'd400;
    for (int f = 1; f <= 205; f++) begin
      @(negedge clk_i);
      tri_s[f] = sample_o[R-1:0];
      repeat (L - 1) @(negedge clk_i);
    end
    chk("tri_f1", 64'(tri_s[1]), 64'd8);
    chk("tri_f2", 64'(tri_s[2]), 64'd16);
    chk("tri_peak", 64'(tri_s[51]), 64'd408);
    chk("tri_turn", 64'(tri_s[52]), 64'd400);
    chk("tri_trough", 64'(tri_s[153]), 64'h3E68);
    chk("tri_turn_up", 64'(tri_s[154]), 64'h3E70);
    chk("tri_period", 64'(tri_s[205]), 64'd8);

    // PRBS on all channels: first shift of seeds ACE1..ACE4
    mode_i = 8'hFF;
    @(negedge clk_i);
    chk("prbs_first", 64'(sample_o), 64'({14'h159C, 14'h389C, 14'h159C, 14'h389C}));

    // Drop enable mid-frame: frame completes, then idle
    repeat (3) @(negedge clk_i);
    en_i = 1'b0;
    repeat (4) @(negedge clk_i);
    @(negedge clk_i);
    chk("idle_lanes", 64'({lane_odd_o, lane_even_o}), 64'd0);
    chk("idle_frame", 64'(frame_o), 64'd0);
    chk("idle_sample_held", 64'(sample_o),
        64'({14'h159C, 14'h389C, 14'h159C, 14'h389C}));
    repeat (4) @(negedge clk_i);
    chk("idle_valid", 64'(sample_valid_o), 64'd0);
    en_i = 1'b1;
    @(negedge clk_i);
    chk("restart_valid", 64'(sample_valid_o), 64'd1);
    chk("restart_frame", 64'(frame_o), 64'd1);
    chk("prbs_second", 64'(sample_o), 64'({14'h0ACE, 14'h314E, 14'h27CE, 14'h1C4E}));

    // Async reset at count 5 of a triangle run on ch0
    mode_i[1:0] = 2'd1;
    repeat (L - 1) @(negedge clk_i);
    @(negedge clk_i);
    repeat (5) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_lanes", 64'({lane_odd_o, lane_even_o}), 64'd0);
    chk("arst_frame", 64'(frame_o), 64'd0);
    chk("arst_valid", 64'(sample_valid_o), 64'd0);
    chk("arst_sample", 64'(sample_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_valid", 64'(sample_valid_o), 64'd1);
    chk("post_rst_sample", 64'(sample_o), 64'({14'h159C, 14'h389C, 14'h159C, 14'd8}));
    repeat (2 * L) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
